mmio_input_port: RTL

- Input peripheral between the board pins (8 switches, 1 push button) and the CPU's memory-mapped load path.
- Synchronizes and debounces the button, and latches the switch byte on each confirmed press.
- Presents live switches, latched switches and status as 32-bit words for CPU `lw` reads, with a one-cycle registered read latency.
- Sits directly upstream of the core's load/writeback path inside `main`.

---
 rtl/mmio_input_port.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mmio_input_port.sv
// Memory-mapped switch/button input port: synchronizes pins, debounces the button and latches
// the switch byte on each confirmed press. Optional press-pending irq under MMIO_INPUT_IRQ_EN.
module mmio_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  Switches,
  input  logic        Button,
  input  logic        io_rd,
  input  logic [1:0]  io_addr,
  output logic [31:0] io_rdata,
  output logic        io_rvalid,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StCheck, StCommit} db_state_e;

  localparam logic [CNT_W-1:0] DbTarget = CNT_W'(DEBOUNCE_CYCLES);

  logic [7:0]       sw_meta_q, sw_s;
  logic             btn_meta_q, btn_s;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             btn_state_q;
  logic             press_evt;
  logic [7:0]       latched_q, latched_d;
  logic             pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             rd_clr;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_q  <= '0;
      sw_s       <= '0;
      btn_meta_q <= 1'b0;
      btn_s      <= 1'b0;
    end else begin
      sw_meta_q  <= Switches;
      sw_s       <= sw_meta_q;
      btn_meta_q <= Button;
      btn_s      <= btn_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      btn_state_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (btn_s != btn_state_q) begin
            state_q <= StCheck;
            cnt_q   <= CNT_W'(1);
          end
        end
        StCheck: begin
          if (btn_s == btn_state_q) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == DbTarget) begin
            state_q <= StCommit;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StCommit: begin
          btn_state_q <= ~btn_state_q;
          cnt_q       <= '0;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Only the rising commit (old state 0) is a press; releases are silent.
  assign press_evt = (state_q == StCommit) && !btn_state_q;
  assign rd_clr    = io_rd && (io_addr == 2'd1);

  always_comb begin
    latched_d  = latched_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (rd_clr) begin
      pending_d  = 1'b0;
      overflow_d = 1'b0;
    end
    // A press colliding with the clearing read wins but starts a fresh, non-overflowed record.
    if (press_evt) begin
      latched_d = sw_s;
      pending_d = 1'b1;
      if (pending_q && !rd_clr) overflow_d = 1'b1;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (io_rd) begin
      case (io_addr)
        2'd0:    rdata_d = {24'b0, sw_s};
        2'd1:    rdata_d = {24'b0, latched_q};
        2'd2:    rdata_d = {30'b0, overflow_q, pending_q};
        default: rdata_d = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      latched_q  <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      latched_q  <= latched_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= io_rd;
    end
  end

  assign io_rdata  = rdata_q;
  assign io_rvalid = rvalid_q;

`ifdef MMIO_INPUT_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= pending_q;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
